vga_plot_arbiter: RTL and testbench

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

---
 rtl/vga_plot_pkg.sv | 23 ++
 rtl/plot_priority_encoder.sv | 19 +
 rtl/vga_plot_arbiter.sv | 161 ++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_plot_pkg.sv
// Shared constants and types for the VGA plot arbiter.
package vga_plot_pkg;

  localparam int unsigned REQ_COUNT = 4;

  localparam int unsigned REQ_CLEAR = 0;
  localparam int unsigned REQ_PIPE  = 1;
  localparam int unsigned REQ_BIRD  = 2;
  localparam int unsigned REQ_SCORE = 3;

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;
  localparam int unsigned C_W = 3;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/plot_priority_encoder.sv
// Combinational fixed-priority picker: lowest index eligible requester wins.
module plot_priority_encoder
  import vga_plot_pkg::*;
(
  input  logic [REQ_COUNT-1:0] eligible,
  output logic [REQ_COUNT-1:0] winner
);

  // Scan upward and keep only the first set bit
  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < REQ_COUNT; i++) begin
      if (eligible[i] && (winner == '0)) begin
        winner[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Burst arbiter sharing one VGA adapter write port between four pixel
// sources (clear, pipes, bird, score). Each of requesters 1..3 is served at
// most once per frame; requester 0 is always eligible.
// Optional build macro PLOT_BOUNDS_CHECK_EN: swallow off-screen pixels and
// count them in droppedCount.
module vga_plot_arbiter
  import vga_plot_pkg::*;
(
  input  logic                     clk,
  input  logic                     resetLow,
  input  logic                     frameTick,
  input  logic [REQ_COUNT-1:0]     req,
  input  logic [REQ_COUNT-1:0]     last,
  input  logic [REQ_COUNT*X_W-1:0] reqX,
  input  logic [REQ_COUNT*Y_W-1:0] reqY,
  input  logic [REQ_COUNT*C_W-1:0] reqColour,
  output logic [REQ_COUNT-1:0]     grant,
  output logic [X_W-1:0]           plotX,
  output logic [Y_W-1:0]           plotY,
  output logic [C_W-1:0]           plotColour,
  output logic                     plotEn,
  output logic                     busy,
  output logic                     frameOverrun
`ifdef PLOT_BOUNDS_CHECK_EN
  ,
  output logic [7:0]               droppedCount
`endif
);

  state_t               state;
  state_t               state_next;
  logic [REQ_COUNT-1:0] grant_next;
  logic [REQ_COUNT-1:0] served;
  logic [REQ_COUNT-1:0] served_next;
  logic                 overrun_next;
  logic                 arb_ready;
  logic [REQ_COUNT-1:0] eligible;
  logic [REQ_COUNT-1:0] winner;
  logic                 plot_hit;
  logic                 sel_last;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [C_W-1:0]       sel_c;
  logic                 in_bounds;

  // served[REQ_CLEAR] is never set, so requester 0 stays eligible
  assign eligible = req & ~served;
  assign busy     = |grant;

  plot_priority_encoder u_prio (
    .eligible (eligible),
    .winner   (winner)
  );

  // Pick the granted requester's pixel slice and end-of-burst marker
  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_c    = '0;
    sel_last = 1'b0;
    for (int unsigned i = 0; i < REQ_COUNT; i++) begin
      if (grant[i]) begin
        sel_x    = reqX[i*X_W +: X_W];
        sel_y    = reqY[i*Y_W +: Y_W];
        sel_c    = reqColour[i*C_W +: C_W];
        sel_last = last[i] & req[i];
      end
    end
  end

  assign plot_hit = (state == BURST) && |(req & grant);

`ifdef PLOT_BOUNDS_CHECK_EN
  localparam logic [X_W-1:0] X_LIMIT = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIMIT = Y_W'(SCREEN_H);
  assign in_bounds = (sel_x < X_LIMIT) && (sel_y < Y_LIMIT);
`else
  assign in_bounds = 1'b1;
`endif

  // Next-state logic: arbitrate in IDLE, track burst completion, frame bookkeeping
  always_comb begin
    state_next   = state;
    grant_next   = grant;
    served_next  = served;
    overrun_next = frameOverrun;

    unique case (state)
      IDLE: begin
        if (arb_ready && (|eligible)) begin
          grant_next = winner;
          state_next = BURST;
        end
      end
      BURST: begin
        if (plot_hit && sel_last) begin
          grant_next             = '0;
          state_next             = IDLE;
          served_next            = served | grant;
          served_next[REQ_CLEAR] = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    // Frame start clears the served set; it overrides a same-cycle completion
    if (frameTick) begin
      served_next = '0;
      if (((state == BURST) && (|grant[REQ_COUNT-1:1])) ||
          (|(req[REQ_COUNT-1:1] & ~served[REQ_COUNT-1:1]))) begin
        overrun_next = 1'b1;
      end
    end
  end

  // Control state register; arb_ready holds off arbitration for the first cycle after reset
  always_ff @(posedge clk) begin
    if (!resetLow) begin
      state        <= IDLE;
      grant        <= '0;
      served       <= '0;
      frameOverrun <= 1'b0;
      arb_ready    <= 1'b0;
    end else begin
      state        <= state_next;
      grant        <= grant_next;
      served       <= served_next;
      frameOverrun <= overrun_next;
      arb_ready    <= 1'b1;
    end
  end

  // Pixel output register: one cycle from accepted request to write strobe
  always_ff @(posedge clk) begin
    if (!resetLow) begin
      plotX      <= '0;
      plotY      <= '0;
      plotColour <= '0;
      plotEn     <= 1'b0;
    end else begin
      plotEn <= plot_hit && in_bounds;
      if (plot_hit) begin
        plotX      <= sel_x;
        plotY      <= sel_y;
        plotColour <= sel_c;
      end
    end
  end

`ifdef PLOT_BOUNDS_CHECK_EN
  // Saturating tally of off-screen pixels that were swallowed
  always_ff @(posedge clk) begin
    if (!resetLow) begin
      droppedCount <= '0;
    end else if (plot_hit && !in_bounds && (droppedCount != '1)) begin
      droppedCount <= droppedCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: requester behaviour and expected
// results come from a transaction-level model; a monitor checks every plot.
module tb_vga_plot_arbiter;

  logic        clk = 1'b0;
  logic        resetLow = 1'b0;
  logic        frameTick = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  last = '0;
  logic [31:0] reqX = '0;
  logic [27:0] reqY = '0;
  logic [11:0] reqColour = '0;
  logic [3:0]  grant;
  logic [7:0]  plotX;
  logic [6:0]  plotY;
  logic [2:0]  plotColour;
  logic        plotEn;
  logic        busy;
  logic        frameOverrun;
`ifdef PLOT_BOUNDS_CHECK_EN
  logic [7:0]  droppedCount;
`endif

  always #5 clk = ~clk;

  vga_plot_arbiter dut (
    .clk          (clk),
    .resetLow     (resetLow),
    .frameTick    (frameTick),
    .req          (req),
    .last         (last),
    .reqX         (reqX),
    .reqY         (reqY),
    .reqColour    (reqColour),
    .grant        (grant),
    .plotX        (plotX),
    .plotY        (plotY),
    .plotColour   (plotColour),
    .plotEn       (plotEn),
    .busy         (busy),
    .frameOverrun (frameOverrun)
`ifdef PLOT_BOUNDS_CHECK_EN
    ,
    .droppedCount (droppedCount)
`endif
  );

  typedef struct { int x; int y; int c; int hold; } pix_t;
  typedef struct { int x; int y; int c; int cyc; } exp_t;

  pix_t pend [4][$];   // pixels each requester still wants to draw
  exp_t sb [$];        // expected plots, oldest first
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // reference model state
  int owner      = -1;
  bit served_m [4];
  bit overrun_m  = 1'b0;
  bit armed_m    = 1'b0;
  int dropped_m  = 0;
  bit tick_next  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected pixel
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (plotEn === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_plotEn", 1, 0);
        end else begin
          e = sb.pop_front();
          check("plotX", int'(plotX), e.x);
          check("plotY", int'(plotY), e.y);
          check("plotColour", int'(plotColour), e.c);
          check("plot_latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

  function automatic bit on_screen(input int x, input int y);
`ifdef PLOT_BOUNDS_CHECK_EN
    return (x < 160) && (y < 120);
`else
    return 1'b1;
`endif
  endfunction

  task automatic add_px(input int r, input int x, input int y, input int c, input int hold);
    pix_t p;
    p.x = x; p.y = y; p.c = c; p.hold = hold;
    pend[r].push_back(p);
  endtask

  task automatic add_burst(input int r, input int n, input bit rnd_hold);
    for (int k = 0; k < n; k++) begin
      add_px(r, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
             int'($urandom_range(0, 7)),
             (rnd_hold && ($urandom_range(0, 4) == 0)) ? int'($urandom_range(1, 3)) : 0);
    end
  endtask

  // One clock: drive requesters, predict the edge, then compare control outputs
  task automatic step();
    logic [3:0] r;
    logic [3:0] l;
    int   nxt_owner;
    int   served_set;
    bit   fire;
    bit   ovr;
    pix_t p;
    exp_t e;
    r = '0;
    l = '0;
    served_set = -1;
    ovr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      reqX[8*i +: 8]      = 8'($urandom);
      reqY[7*i +: 7]      = 7'($urandom);
      reqColour[3*i +: 3] = 3'($urandom);
      if (pend[i].size() > 0) begin
        if (pend[i][0].hold > 0) begin
          p = pend[i][0];
          p.hold = p.hold - 1;
          pend[i][0] = p;
        end else begin
          r[i] = 1'b1;
          l[i] = (pend[i].size() == 1);
          reqX[8*i +: 8]      = 8'(pend[i][0].x);
          reqY[7*i +: 7]      = 7'(pend[i][0].y);
          reqColour[3*i +: 3] = 3'(pend[i][0].c);
        end
      end
      if (!r[i]) l[i] = 1'($urandom_range(0, 1));
    end
    fire = tick_next;
    tick_next = 1'b0;

    nxt_owner = owner;
    if (owner < 0) begin
      if (armed_m) begin
        for (int i = 0; i < 4; i++) begin
          if ((nxt_owner < 0) && r[i] && ((i == 0) || !served_m[i])) nxt_owner = i;
        end
      end
    end else if (r[owner]) begin
      p = pend[owner].pop_front();
      if (on_screen(p.x, p.y)) begin
        e.x = p.x; e.y = p.y; e.c = p.c; e.cyc = cyc + 1;
        sb.push_back(e);
      end else if (dropped_m < 255) begin
        dropped_m++;
      end
      if (l[owner]) begin
        nxt_owner = -1;
        if (owner > 0) served_set = owner;
      end
    end
    if (fire) begin
      if (owner > 0) ovr = 1'b1;
      for (int i = 1; i < 4; i++) if (r[i] && !served_m[i]) ovr = 1'b1;
    end

    req = r;
    last = l;
    frameTick = fire;
    @(posedge clk);
    #1;
    owner = nxt_owner;
    if (served_set > 0) served_m[served_set] = 1'b1;
    if (fire) for (int i = 1; i < 4; i++) served_m[i] = 1'b0;
    if (ovr) overrun_m = 1'b1;
    armed_m = 1'b1;

    check("grant", int'(grant), (owner < 0) ? 0 : (1 << owner));
    check("busy", int'(busy), (owner >= 0) ? 1 : 0);
    check("frameOverrun", int'(frameOverrun), int'(overrun_m));
`ifdef PLOT_BOUNDS_CHECK_EN
    check("droppedCount", int'(droppedCount), dropped_m);
`endif
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  function automatic bit work_left();
    bit any;
    any = (owner >= 0);
    for (int i = 0; i < 4; i++) if (pend[i].size() > 0) any = 1'b1;
    return any;
  endfunction

  // Run until every requester is done; bounded so a stuck DUT still ends the test
  task automatic drain(input int budget, input bit auto_tick);
    int n;
    n = 0;
    while (work_left() && (n < budget)) begin
      if (auto_tick) tick_next = ($urandom_range(0, 15) == 0);
      step();
      n++;
    end
    if (work_left()) begin
      check("drain_timeout", 1, 0);
      for (int i = 0; i < 4; i++) pend[i].delete();
    end
  endtask

  task automatic do_reset(input int n);
    resetLow  = 1'b0;
    req       = '0;
    last      = '0;
    frameTick = 1'b0;
    tick_next = 1'b0;
    for (int i = 0; i < 4; i++) pend[i].delete();
    repeat (n) @(posedge clk);
    #1;
    check("rst_grant", int'(grant), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_plotEn", int'(plotEn), 0);
    check("rst_plotX", int'(plotX), 0);
    check("rst_plotY", int'(plotY), 0);
    check("rst_plotColour", int'(plotColour), 0);
    check("rst_frameOverrun", int'(frameOverrun), 0);
`ifdef PLOT_BOUNDS_CHECK_EN
    check("rst_droppedCount", int'(droppedCount), 0);
`endif
    owner = -1;
    for (int i = 0; i < 4; i++) served_m[i] = 1'b0;
    overrun_m = 1'b0;
    armed_m   = 1'b0;
    dropped_m = 0;
    resetLow  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(3);

    // Two requesters at once: pipes first, bird after one idle cycle
    add_burst(1, 3, 1'b0);
    add_burst(2, 2, 1'b0);
    drain(40, 1'b0);

    // New frame, then a known bird pixel
    tick_next = 1'b1;
    step();
    add_px(2, 10, 20, 3'b100, 0);
    drain(10, 1'b0);

    // Pipes served this frame: re-request waits for frameTick
    tick_next = 1'b1;
    step();
    add_burst(1, 2, 1'b0);
    drain(10, 1'b0);
    add_burst(1, 1, 1'b0);
    run(5);
    tick_next = 1'b1;
    step();
    drain(10, 1'b0);

    // Bird pauses two cycles mid-burst; screen clear asks meanwhile and must wait
    tick_next = 1'b1;
    step();
    add_px(2, 30, 40, 1, 0);
    add_px(2, 31, 40, 2, 2);
    add_px(2, 32, 40, 3, 0);
    run(3);
    add_burst(0, 2, 1'b0);
    drain(20, 1'b0);

    // frameTick during score burst sets the sticky overrun; reset clears it mid-burst
    add_burst(3, 6, 1'b0);
    run(3);
    tick_next = 1'b1;
    step();
    run(2);
    do_reset(2);

    // Screen-edge pixels
    add_px(0, 160, 5, 6, 0);
    add_px(0, 159, 119, 5, 0);
    add_px(0, 0, 0, 7, 0);
    add_px(0, 255, 127, 1, 0);
    drain(20, 1'b0);

    // Randomised traffic with random frame ticks and occasional resets
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 2) == 0) add_burst(i, int'($urandom_range(1, 4)), 1'b1);
      end
      if ((it % 13) == 12) begin
        run(int'($urandom_range(1, 6)));
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        drain(400, 1'b1);
      end
      run(int'($urandom_range(0, 2)));
    end

    run(3);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
